// File: rtl/gate_tester.sv
// Self-test sequencer for a 2-input gate: steps {A,B} through 00..11, samples result_in after a settle window.
// Latency 4*(SETTLE_CYCLES+1)+1 cycles from start to done; start is ignored (never queued) outside IDLE.
module gate_tester #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECTED      = 4'b1000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       result_in,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [1:0] vector
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [1:0] vector_q, vector_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] fail_mask_q, fail_mask_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d     = state_q;
    vector_d    = vector_q;
    cnt_d       = cnt_q;
    fail_mask_d = fail_mask_q;
    pass_d      = pass_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d     = ST_APPLY;
          vector_d    = 2'd0;
          cnt_d       = 4'd0;
          fail_mask_d = 4'b0000;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
        end
      end
      ST_APPLY: begin
        if (cnt_q == SETTLE_LIM) begin
          if (result_in != EXPECTED[vector_q]) begin
            fail_mask_d[vector_q] = 1'b1;
          end
          cnt_d = 4'd0;
          if (vector_q == 2'd3) begin
            // pass must already reflect the mismatch recorded on this same edge
            state_d  = ST_DONE;
            vector_d = 2'd0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            pass_d   = (fail_mask_d == 4'b0000);
          end else begin
            vector_d = vector_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = ST_IDLE;
        vector_d = 2'd0;
        cnt_d    = 4'd0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      vector_q    <= 2'd0;
      cnt_q       <= 4'd0;
      fail_mask_q <= 4'b0000;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vector_q    <= vector_d;
      cnt_q       <= cnt_d;
      fail_mask_q <= fail_mask_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // vector is zero outside APPLY, so A/B come straight from its flops glitch-free
  assign A         = vector_q[1];
  assign B         = vector_q[0];
  assign vector    = vector_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_tester.sv
// Bench for gate_tester: two instances (settle 2 and settle 0) each driving a table-selected gate model.
module tb_gate_tester;

  localparam int         S0     = 2;
  localparam int         S1     = 0;
  localparam logic [3:0] EXP_TT = 4'b1000;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       start_i   [2];
  logic       a_o       [2];
  logic       b_o       [2];
  logic       busy_o    [2];
  logic       done_o    [2];
  logic       pass_o    [2];
  logic [3:0] mask_o    [2];
  logic [1:0] vec_o     [2];
  logic [3:0] tt        [2];
  logic       res       [2];

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  // gate under test: truth table indexed by {A,B}
  assign res[0] = tt[0][{a_o[0], b_o[0]}];
  assign res[1] = tt[1][{a_o[1], b_o[1]}];

  gate_tester #(.SETTLE_CYCLES(S0), .EXPECTED(EXP_TT)) u0 (
    .Clk(Clk), .Reset(Reset), .start(start_i[0]), .result_in(res[0]),
    .A(a_o[0]), .B(b_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .pass(pass_o[0]), .fail_mask(mask_o[0]), .vector(vec_o[0])
  );

  gate_tester #(.SETTLE_CYCLES(S1), .EXPECTED(EXP_TT)) u1 (
    .Clk(Clk), .Reset(Reset), .start(start_i[1]), .result_in(res[1]),
    .A(a_o[1]), .B(b_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .pass(pass_o[1]), .fail_mask(mask_o[1]), .vector(vec_o[1])
  );

  typedef struct {
    string      name;
    logic [3:0] gate;
    logic [3:0] exp_mask;
    logic       exp_pass;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int settle_of(input int u);
    return (u == 0) ? S0 : S1;
  endfunction

  function automatic logic [5:0] outs(input int u);
    return {busy_o[u], done_o[u], a_o[u], b_o[u], vec_o[u]};
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One full run; cycle k counts from the edge that samples start (k=0).
  task automatic run(input int u, input logic [3:0] g, input bit repulse, input string nm);
    int         s;
    int         last;
    logic [3:0] m;
    logic [1:0] v;
    s    = settle_of(u);
    last = 4 * (s + 1) + 1;
    for (int i = 0; i < 4; i++) m[i] = (g[i] != EXP_TT[i]);
    tt[u]      = g;
    start_i[u] = 1'b1;
    step();
    start_i[u] = 1'b0;
    for (int k = 1; k <= last; k++) begin
      if (k < last) begin
        v = 2'((k - 1) / (s + 1));
        chk({nm, "/apply"}, 32'(outs(u)), 32'({1'b1, 1'b0, v[1], v[0], v}));
      end else begin
        chk({nm, "/done"}, 32'(outs(u)), 32'(6'b010000));
        chk({nm, "/pass"}, 32'(pass_o[u]), 32'(m == 4'b0000));
        chk({nm, "/mask"}, 32'(mask_o[u]), 32'(m));
      end
      if (repulse) start_i[u] = (k == 4 || k == 8);
      if (k < last) step();
    end
    start_i[u] = 1'b0;
    step();
    chk({nm, "/idle"}, 32'(outs(u)), 32'(0));
    chk({nm, "/pass_hold"}, 32'(pass_o[u]), 32'(m == 4'b0000));
    chk({nm, "/mask_hold"}, 32'(mask_o[u]), 32'(m));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    tbl[0] = '{"and",  4'b1000, 4'b0000, 1'b1};
    tbl[1] = '{"tie0", 4'b0000, 4'b1000, 1'b0};
    tbl[2] = '{"or",   4'b1110, 4'b0110, 1'b0};
    tbl[3] = '{"xor",  4'b0110, 4'b1110, 1'b0};
    tbl[4] = '{"tie1", 4'b1111, 4'b0111, 1'b0};
    tbl[5] = '{"nand", 4'b0111, 4'b1111, 1'b0};

    Reset      = 1'b1;
    start_i[0] = 1'b0;
    start_i[1] = 1'b0;
    tt[0]      = 4'b0000;
    tt[1]      = 4'b0000;
    repeat (3) step();
    Reset = 1'b0;
    step();
    for (int u = 0; u < 2; u++) begin
      chk("reset/outs", 32'(outs(u)), 32'(0));
      chk("reset/pass", 32'(pass_o[u]), 32'(0));
      chk("reset/mask", 32'(mask_o[u]), 32'(0));
    end

    // table: explicit mask/pass per gate, both settle settings
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 6; i++) begin
        tt[u] = tbl[i].gate;
        run(u, tbl[i].gate, 1'b0, tbl[i].name);
        chk({tbl[i].name, "/tbl_mask"}, 32'(mask_o[u]), 32'(tbl[i].exp_mask));
        chk({tbl[i].name, "/tbl_pass"}, 32'(pass_o[u]), 32'(tbl[i].exp_pass));
        step();
      end
    end

    // start re-pulsed mid-run is ignored
    run(0, 4'b1000, 1'b1, "repulse");

    // start held high: DONE in 13, IDLE in 14, second APPLY from 15, second done in 27
    tt[0]      = 4'b1000;
    start_i[0] = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      step();
      if (k == 13) chk("hold/done1", 32'(outs(0)), 32'(6'b010000));
      if (k == 14) chk("hold/idle", 32'(outs(0)), 32'(0));
      if (k == 15) chk("hold/apply2", 32'(outs(0)), 32'(6'b100000));
      if (k == 27) begin
        chk("hold/done2", 32'(outs(0)), 32'(6'b010000));
        chk("hold/pass2", 32'(pass_o[0]), 32'(1));
        start_i[0] = 1'b0;
      end
      if (k == 28) chk("hold/idle2", 32'(outs(0)), 32'(0));
    end

    // reset mid-run discards partial results
    tt[0]      = 4'b0111;
    start_i[0] = 1'b1;
    step();
    start_i[0] = 1'b0;
    repeat (4) step();
    chk("rst/mask_mid", 32'(mask_o[0]), 32'(4'b0001));
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("rst/outs", 32'(outs(0)), 32'(0));
    chk("rst/mask", 32'(mask_o[0]), 32'(0));
    chk("rst/pass", 32'(pass_o[0]), 32'(0));
    run(0, 4'b1000, 1'b0, "post_rst");

    // randomized gates against the per-vector model
    for (int i = 0; i < 40; i++) begin
      int gap;
      run(i % 2, 4'($urandom), 1'b0, "rand");
      gap = int'($urandom_range(0, 2));
      repeat (gap) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
